// File: rtl/or1200_defines_pkg.sv
// Shared widths, opcode constants and helpers for the OR1200 EX/WB datapath slice.
package or1200_defines_pkg;

    localparam int OR1200_OPERAND_WIDTH = 32;
    localparam int OR1200_ALUOP_WIDTH   = 5;
    localparam int OR1200_ALUOP2_WIDTH  = 4;
    localparam int OR1200_COMPOP_WIDTH  = 4;
    localparam int OR1200_RFWBOP_WIDTH  = 4;
    localparam int OR1200_CUST5_WORDS   = 16;

    localparam logic [4:0] OR1200_ALUOP_ADD   = 5'b00000;
    localparam logic [4:0] OR1200_ALUOP_ADDC  = 5'b00001;
    localparam logic [4:0] OR1200_ALUOP_SUB   = 5'b00010;
    localparam logic [4:0] OR1200_ALUOP_AND   = 5'b00011;
    localparam logic [4:0] OR1200_ALUOP_OR    = 5'b00100;
    localparam logic [4:0] OR1200_ALUOP_XOR   = 5'b00101;
    localparam logic [4:0] OR1200_ALUOP_MUL   = 5'b00110;
    localparam logic [4:0] OR1200_ALUOP_SHROT = 5'b01000;
    localparam logic [4:0] OR1200_ALUOP_MOVHI = 5'b01100;
    localparam logic [4:0] OR1200_ALUOP_CMOV  = 5'b01110;
    localparam logic [4:0] OR1200_ALUOP_FF1   = 5'b01111;
    localparam logic [4:0] OR1200_ALUOP_CUST5 = 5'b10010;

    typedef enum logic [1:0] {
        SHROT_SLL = 2'b00,
        SHROT_SRL = 2'b01,
        SHROT_SRA = 2'b10,
        SHROT_ROR = 2'b11
    } shrot_op_e;

    localparam logic [4:0] OR1200_CUST5_TAIL  = 5'b00001;
    localparam logic [4:0] OR1200_CUST5_BODY  = 5'b00010;
    localparam logic [4:0] OR1200_CUST5_HEAD  = 5'b00100;
    localparam logic [4:0] OR1200_CUST5_STORE = 5'b01000;

    localparam logic [2:0] OR1200_RFWB_SEL_PC8 = 3'b011;
    localparam logic [2:0] OR1200_RFWB_SEL_MAC = 3'b101;

    typedef struct packed {
        logic [2:0] sel;
        logic       we;
    } rfwb_op_t;

    // 1-based position of the lowest set bit; 0 when no bit is set.
    function automatic logic [31:0] ff1(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/or1200_cust5_msgbuf.sv
// l.cust5 message staging buffer: sixteen 32-bit words filled in arrival
// order from the top slot down, with a word-count, a done latch and a read port.
module or1200_cust5_msgbuf
    import or1200_defines_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [4:0]  op_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] result_o
);

    logic [31:0] word_q [OR1200_CUST5_WORDS];
    logic [31:0] word_d [OR1200_CUST5_WORDS];
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (en_i) begin
            case (op_i)
                OR1200_CUST5_HEAD: begin
                    for (int i = 0; i < OR1200_CUST5_WORDS; i++) word_d[i] = '0;
                    word_d[OR1200_CUST5_WORDS-1] = data_i;
                    cnt_d  = 5'd1;
                    done_d = 1'b0;
                end
                OR1200_CUST5_BODY: begin
                    if (!done_q && (cnt_q < 5'd16)) begin
                        word_d[4'd15 - cnt_q[3:0]] = data_i;
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                OR1200_CUST5_TAIL: done_d = 1'b1;
                default: ;
            endcase
        end
    end

    // STORE reads the pre-edge contents; the control ops report the updated count.
    always_comb begin
        result_o = '0;
        case (op_i)
            OR1200_CUST5_STORE: result_o = word_q[sel_i];
            OR1200_CUST5_HEAD,
            OR1200_CUST5_BODY,
            OR1200_CUST5_TAIL:  result_o = {27'b0, cnt_d};
            default:            result_o = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < OR1200_CUST5_WORDS; i++) word_q[i] <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            for (int i = 0; i < OR1200_CUST5_WORDS; i++) word_q[i] <= word_d[i];
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/or1200_cpu_tmp_total_dp.sv
// Reduced OR1200 execute/write-back slice: ALU, l.cust5 message buffer and a
// registered write-back mux, with a free-running stub EX program counter.
module or1200_cpu_tmp_total_dp
    import or1200_defines_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] mult_mac_result,
    input  logic        macrc_op,
    input  logic [4:0]  alu_op,
    input  logic [3:0]  alu_op2,
    input  logic [3:0]  comp_op,
    input  logic [4:0]  cust5_op,
    input  logic [5:0]  cust5_limm,
    input  logic        carry,
    input  logic        flag,
    input  logic [3:0]  rfwb_op,
    output logic [31:0] ex_pc,
    output logic [31:0] rf_dataw
);

    logic [31:0] ex_pc_q, ex_pc_d;
    logic [31:0] rf_dataw_q, rf_dataw_d;
    logic [31:0] alu_result;
    logic [31:0] shrot_result;
    logic [31:0] cust5_result;
    logic [31:0] wb_data;
    logic [4:0]  shamt;
    logic [63:0] ror_wide;
    rfwb_op_t    rfwb;
    logic        unused_inputs;

    assign rfwb  = rfwb_op_t'(rfwb_op);
    assign shamt = operand_b[4:0];

    or1200_cust5_msgbuf u_cust5 (
        .clk      (clk),
        .rst      (rst),
        .en_i     (alu_op == OR1200_ALUOP_CUST5),
        .op_i     (cust5_op),
        .sel_i    (cust5_limm[3:0]),
        .data_i   (operand_a),
        .result_o (cust5_result)
    );

    // Rotate by shifting a doubled copy so a zero amount needs no special case.
    assign ror_wide = {operand_a, operand_a} >> shamt;

    always_comb begin
        shrot_result = '0;
        case (shrot_op_e'(alu_op2[1:0]))
            SHROT_SLL: shrot_result = operand_a << shamt;
            SHROT_SRL: shrot_result = operand_a >> shamt;
            SHROT_SRA: shrot_result = $unsigned($signed(operand_a) >>> shamt);
            SHROT_ROR: shrot_result = ror_wide[31:0];
            default:   shrot_result = '0;
        endcase
    end

    always_comb begin
        alu_result = '0;
        if (macrc_op) begin
            alu_result = mult_mac_result;
        end else begin
            case (alu_op)
                OR1200_ALUOP_ADD:   alu_result = operand_a + operand_b;
                OR1200_ALUOP_ADDC:  alu_result = operand_a + operand_b + {31'b0, carry};
                OR1200_ALUOP_SUB:   alu_result = operand_a - operand_b;
                OR1200_ALUOP_AND:   alu_result = operand_a & operand_b;
                OR1200_ALUOP_OR:    alu_result = operand_a | operand_b;
                OR1200_ALUOP_XOR:   alu_result = operand_a ^ operand_b;
                OR1200_ALUOP_MUL:   alu_result = mult_mac_result;
                OR1200_ALUOP_SHROT: alu_result = shrot_result;
                OR1200_ALUOP_MOVHI: alu_result = {operand_b[15:0], 16'h0000};
                OR1200_ALUOP_CMOV:  alu_result = flag ? operand_a : operand_b;
                OR1200_ALUOP_FF1:   alu_result = ff1(operand_a);
                OR1200_ALUOP_CUST5: alu_result = cust5_result;
                default:            alu_result = '0;
            endcase
        end
    end

    always_comb begin
        case (rfwb.sel)
            OR1200_RFWB_SEL_PC8: wb_data = ex_pc_q + 32'd8;
            OR1200_RFWB_SEL_MAC: wb_data = mult_mac_result;
            default:             wb_data = alu_result;
        endcase
    end

    assign rf_dataw_d = rfwb.we ? wb_data : rf_dataw_q;
    assign ex_pc_d    = ex_pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_pc_q    <= '0;
            rf_dataw_q <= '0;
        end else begin
            ex_pc_q    <= ex_pc_d;
            rf_dataw_q <= rf_dataw_d;
        end
    end

    assign ex_pc    = ex_pc_q;
    assign rf_dataw = rf_dataw_q;

    // No flag output exists in this slice, so the compare op is sunk here.
    assign unused_inputs = ^{comp_op, alu_op2[3:2], cust5_limm[5:4], ror_wide[63:32]};

endmodule

// File: tb/tb_or1200_cpu_tmp_total_dp.sv
// Directed plus randomized checks of the EX/WB slice against a queue-based reference model.
module tb_or1200_cpu_tmp_total_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] operand_a, operand_b, mult_mac_result;
    logic        macrc_op;
    logic [4:0]  alu_op;
    logic [3:0]  alu_op2;
    logic [3:0]  comp_op;
    logic [4:0]  cust5_op;
    logic [5:0]  cust5_limm;
    logic        carry, flag;
    logic [3:0]  rfwb_op;
    logic [31:0] ex_pc, rf_dataw;

    or1200_cpu_tmp_total_dp dut (
        .clk             (clk),
        .rst             (rst),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .mult_mac_result (mult_mac_result),
        .macrc_op        (macrc_op),
        .alu_op          (alu_op),
        .alu_op2         (alu_op2),
        .comp_op         (comp_op),
        .cust5_op        (cust5_op),
        .cust5_limm      (cust5_limm),
        .carry           (carry),
        .flag            (flag),
        .rfwb_op         (rfwb_op),
        .ex_pc           (ex_pc),
        .rf_dataw        (rf_dataw)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] msg_q [$];
    bit          msg_done = 1'b0;
    logic [31:0] exp_rf   = '0;
    logic [31:0] exp_pc   = '0;

    localparam logic [4:0] C_HEAD = 5'b00100, C_BODY = 5'b00010,
                           C_TAIL = 5'b00001, C_STORE = 5'b01000;
    localparam logic [4:0] OP_CUST5 = 5'b10010;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_store(input logic [3:0] slot);
        int k;
        k = 15 - int'(slot);
        return (k < msg_q.size()) ? msg_q[k] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_shift(input logic [1:0] kind, input logic [31:0] a, input int s);
        case (kind)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return a[31] ? ((a >> s) | ~(32'hFFFF_FFFF >> s)) : (a >> s);
            default: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
        endcase
    endfunction

    function automatic logic [31:0] ref_ff1(input logic [31:0] a);
        for (int i = 0; i < 32; i++) if (a[i]) return 32'(i + 1);
        return 32'h0;
    endfunction

    // Predict from pre-edge model state, advance one edge, compare outputs.
    task automatic cycle(input string tag);
        logic [31:0] res, src;
        case (alu_op)
            5'b00000: res = operand_a + operand_b;
            5'b00001: res = operand_a + operand_b + 32'(carry);
            5'b00010: res = operand_a - operand_b;
            5'b00011: res = operand_a & operand_b;
            5'b00100: res = operand_a | operand_b;
            5'b00101: res = operand_a ^ operand_b;
            5'b00110: res = mult_mac_result;
            5'b01000: res = ref_shift(alu_op2[1:0], operand_a, int'(operand_b[4:0]));
            5'b01100: res = operand_b << 16;
            5'b01110: res = flag ? operand_a : operand_b;
            5'b01111: res = ref_ff1(operand_a);
            OP_CUST5: res = (cust5_op == C_STORE) ? ref_store(cust5_limm[3:0]) : 32'h0;
            default:  res = 32'h0;
        endcase
        if (alu_op == OP_CUST5) begin
            case (cust5_op)
                C_HEAD: begin msg_q.delete(); msg_q.push_back(operand_a); msg_done = 1'b0; end
                C_BODY: if (!msg_done && msg_q.size() < 16) msg_q.push_back(operand_a);
                C_TAIL: msg_done = 1'b1;
                default: ;
            endcase
            if (cust5_op == C_HEAD || cust5_op == C_BODY || cust5_op == C_TAIL)
                res = 32'(msg_q.size());
        end
        if (macrc_op) res = mult_mac_result;
        case (rfwb_op[3:1])
            3'b011:  src = exp_pc + 32'd8;
            3'b101:  src = mult_mac_result;
            default: src = res;
        endcase
        if (!rst) begin
            msg_q.delete();
            msg_done = 1'b0;
            exp_rf   = '0;
            exp_pc   = '0;
        end else begin
            if (rfwb_op[0]) exp_rf = src;
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        chk({tag, ":rf_dataw"}, rf_dataw, exp_rf);
        chk({tag, ":ex_pc"}, ex_pc, exp_pc);
    endtask

    task automatic drive(input logic [4:0] aop, input logic [3:0] aop2,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] rfwb);
        rst = 1'b1; alu_op = aop; alu_op2 = aop2; operand_a = a; operand_b = b;
        rfwb_op = rfwb; macrc_op = 1'b0; cust5_op = '0; cust5_limm = '0;
        comp_op = '0; carry = 1'b0; flag = 1'b0; mult_mac_result = '0;
    endtask

    task automatic c5(input logic [4:0] op, input logic [5:0] limm,
                      input logic [31:0] a, input string tag);
        drive(OP_CUST5, 4'h0, a, 32'h0, 4'b0001);
        cust5_op = op; cust5_limm = limm;
        cycle(tag);
    endtask

    logic [31:0] fox [11];
    logic [31:0] sat_words [18];
    logic [4:0]  op_tab [16];
    logic [4:0]  c5_tab [8];

    initial begin
        fox = '{32'h54686520, 32'h71756963, 32'h6B206272, 32'h6F776E20,
                32'h666F7820, 32'h6A756D70, 32'h73206F76, 32'h65722074,
                32'h6865206C, 32'h617A7920, 32'h646F672E};
        op_tab = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                   5'b00110, 5'b01000, 5'b01100, 5'b01110, 5'b01111, OP_CUST5,
                   OP_CUST5, OP_CUST5, OP_CUST5, 5'b11111};
        c5_tab = '{C_HEAD, C_BODY, C_BODY, C_BODY, C_TAIL, C_STORE, C_STORE, 5'b10000};

        // Reset
        drive(5'b00000, 4'h0, 32'h0, 32'h0, 4'b0000);
        rst = 1'b0;
        cycle("reset0");
        cycle("reset1");
        chk("reset_rf_zero", rf_dataw, 32'h0);
        chk("reset_pc_zero", ex_pc, 32'h0);

        // ADD and PC counting
        drive(5'b00000, 4'h0, 32'd5, 32'd7, 4'b1111);
        cycle("add");
        chk("add_5_7", rf_dataw, 32'd12);
        chk("pc_after_1", ex_pc, 32'd4);
        drive(5'b00000, 4'h0, 32'd1, 32'd1, 4'b0000);
        cycle("hold");
        chk("hold_rf", rf_dataw, 32'd12);
        chk("pc_after_2", ex_pc, 32'd8);
        drive(5'b00000, 4'h0, 32'd0, 32'd0, 4'b0111);
        cycle("wb_pc8");
        chk("wb_pc8_const", rf_dataw, 32'd16);

        // Fox message
        c5(C_HEAD, 6'd0, fox[0], "fox_head");
        for (int i = 1; i < 11; i++) c5(C_BODY, 6'd0, fox[i], "fox_body");
        c5(C_TAIL, 6'd0, 32'h0, "fox_tail");
        chk("fox_cnt11", rf_dataw, 32'd11);
        c5(C_STORE, 6'd15, 32'h0, "st15");
        chk("fox_st15", rf_dataw, 32'h54686520);
        c5(C_STORE, 6'd14, 32'h0, "st14");
        chk("fox_st14", rf_dataw, 32'h71756963);
        c5(C_STORE, 6'd5, 32'h0, "st5");
        chk("fox_st5", rf_dataw, 32'h646F672E);
        c5(C_STORE, 6'd4, 32'h0, "st4");
        chk("fox_st4", rf_dataw, 32'h0);
        c5(C_STORE, 6'h3F, 32'h0, "st_limm_hi");
        chk("fox_st_hi_ignored", rf_dataw, 32'h54686520);

        // SHROT
        for (int k = 0; k < 4; k++) begin
            drive(5'b01000, 4'(k), 32'h80000001, 32'd1, 4'b0001);
            cycle("shrot");
            case (k)
                0: chk("sll", rf_dataw, 32'h00000002);
                1: chk("srl", rf_dataw, 32'h40000000);
                2: chk("sra", rf_dataw, 32'hC0000000);
                default: chk("ror", rf_dataw, 32'hC0000000);
            endcase
        end

        // Saturation at 16 words
        for (int i = 0; i < 18; i++) sat_words[i] = $urandom;
        c5(C_HEAD, 6'd0, sat_words[0], "sat_head");
        for (int i = 1; i < 18; i++) c5(C_BODY, 6'd0, sat_words[i], "sat_body");
        chk("sat_cnt16", rf_dataw, 32'd16);
        c5(C_STORE, 6'd0, 32'h0, "sat_st0");
        chk("sat_word16", rf_dataw, sat_words[15]);
        c5(C_TAIL, 6'd0, 32'h0, "sat_tail");
        c5(C_BODY, 6'd0, 32'hFFFF_FFFF, "body_after_tail");
        chk("body_after_tail_cnt", rf_dataw, 32'd16);
        c5(C_STORE, 6'd0, 32'h0, "sat_st0b");
        chk("sat_word16_kept", rf_dataw, sat_words[15]);

        // Write-enable low holds; reset mid-message
        c5(C_HEAD, 6'd0, 32'h11112222, "mid_head");
        c5(C_BODY, 6'd0, 32'h33334444, "mid_body");
        drive(5'b00000, 4'h0, 32'h100, 32'h200, 4'b1110);
        cycle("we_low");
        chk("we_low_holds", rf_dataw, 32'd2);
        drive(OP_CUST5, 4'h0, 32'h55556666, 32'h0, 4'b0001);
        cust5_op = C_BODY;
        rst = 1'b0;
        cycle("rst_mid");
        chk("rst_mid_rf", rf_dataw, 32'h0);
        chk("rst_mid_pc", ex_pc, 32'h0);
        c5(C_STORE, 6'd15, 32'h0, "post_rst_st15");
        chk("post_rst_st15_zero", rf_dataw, 32'h0);

        // MAC override and CMOV
        drive(5'($urandom_range(0, 31)), 4'h0, 32'h1, 32'h2, 4'b0001);
        macrc_op = 1'b1; mult_mac_result = 32'hDEADBEEF;
        cycle("macrc");
        chk("macrc_deadbeef", rf_dataw, 32'hDEADBEEF);
        drive(5'b01110, 4'h0, 32'hAAAA0001, 32'hBBBB0002, 4'b0001);
        flag = 1'b1;
        cycle("cmov1");
        chk("cmov_flag1", rf_dataw, 32'hAAAA0001);
        flag = 1'b0;
        cycle("cmov0");
        chk("cmov_flag0", rf_dataw, 32'hBBBB0002);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst             = ($urandom_range(0, 59) != 0);
            alu_op          = op_tab[$urandom_range(0, 15)];
            if (alu_op == 5'b11111) alu_op = 5'($urandom);
            alu_op2         = 4'($urandom);
            comp_op         = 4'($urandom);
            cust5_op        = c5_tab[$urandom_range(0, 7)];
            cust5_limm      = 6'($urandom);
            operand_a       = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            operand_b       = $urandom;
            mult_mac_result = $urandom;
            macrc_op        = ($urandom_range(0, 9) == 0);
            carry           = 1'($urandom);
            flag            = 1'($urandom);
            rfwb_op         = 4'($urandom);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/or1200_cpu_tmp_total_dp.md
# or1200_cpu_tmp_total_dp

Reduced OR1200 execute/write-back datapath slice with one registered write-back output. It combines an OR1200-coded ALU, a custom `l.cust5` unit that stages a 512-bit message buffer (front end for a later SHA3-512 core), and a write-back mux. The slice is a standalone bring-up vehicle: no decode, fetch or LSU, and operands and opcodes are driven directly at the ports.

## Interface
Parameters: none. Widths are fixed: data 32, ALUOP 5, ALUOP2 4, COMPOP 4, RFWBOP 4.

Clock and reset: one clock; reset is synchronous and active-low.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- operand_a  in  32  ALU operand A; data word for cust5 HEAD/BODY
- operand_b  in  32  ALU operand B
- mult_mac_result  in  32  external multiplier/MAC result
- macrc_op  in  1  1 forces the ALU result to mult_mac_result
- alu_op  in  5  ALU opcode
- alu_op2  in  4  shift sub-op
- comp_op  in  4  compare op; accepted but unused (no flag output)
- cust5_op  in  5  cust5 sub-op
- cust5_limm  in  6  cust5 immediate; [3:0] is the word select
- carry  in  1  carry-in for ADDC
- flag  in  1  condition for CMOV
- rfwb_op  in  4  [0] write enable, [3:1] source select
- ex_pc  out  32  stub EX program counter
- rf_dataw  out  32  registered write-back data

## Operation
ALU result, combinational:
- 00000 ADD: a+b
- 00001 ADDC: a+b+carry
- 00010 SUB: a−b
- 00011 AND, 00100 OR, 00101 XOR: bitwise
- 00110 MUL: mult_mac_result
- 01000 SHROT, by alu_op2[1:0], amount b[4:0]: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- 01100 MOVHI: {b[15:0],16'h0}
- 01110 CMOV: flag ? a : b
- 01111 FF1: 1-based index of lowest set bit of a, 0 if a==0
- 10010 CUST5: cust5 result
- others: 0
- macrc_op=1 overrides every alu_op.
- All arithmetic is modulo 2^32.

cust5 state: in512[511:0], cnt (0..16), done.
- Action only on cycles with alu_op==CUST5.
- Word k (0-based, in arrival order) is stored at in512[32·(15−k)+:32].
- 00100 HEAD: in512←0, then in512[511:480]←operand_a; cnt←1; done←0.
- 00010 BODY: if !done and cnt<16, write operand_a to slot cnt and cnt++. Otherwise ignored.
- 00001 TAIL: done←1, idempotent. No padding is inserted.
- 01000 STORE: no state change.
- cust5 result:
  - STORE returns in512[32·limm[3:0]+:32].
  - HEAD, BODY and TAIL return {27'b0,cnt} after update.
  - Other sub-ops return 0.
- cust5_limm[5:4] is ignored.

Write-back source by rfwb_op[3:1]:
- 011: ex_pc+8
- 101: mult_mac_result
- all others, including 000 and 111: ALU result

## Timing
- All state updates on the rising edge of clk.
- rf_dataw ← selected source when rfwb_op[0]=1; holds otherwise. Latency 1 cycle.
- cust5 buffer writes land on the same edge. STORE reads pre-edge state, so a STORE following BODY sees the new word.
- ex_pc: 0 on reset, then +4 every cycle.
- Reset (rst=0 at an edge) sets rf_dataw=0, ex_pc=0, in512=0, cnt=0, done=0. Reset has priority over any simultaneous op and cleanly aborts a message mid-stream.
- No handshake. One op per cycle. Holding an op for N cycles executes it N times:
  - BODY repeats write successive slots.
  - HEAD, TAIL and STORE repeats are harmless.
- cnt saturates at 16; further BODY is dropped.

## Structure
- Shared package `or1200_defines_pkg`: ALUOP/ALUOP2/COMPOP/RFWBOP widths, ALU opcode constants, cust5 sub-op constants, RFWB select codes.
- One natural sub-module: `or1200_cust5_msgbuf` (in512/cnt/done and the STORE read mux). ALU and wbmux stay inline.

## Test plan
- Reset then ADD: a=5, b=7, rfwb_op=4'b1111 → rf_dataw=12 one edge later. ex_pc counts 0,4,8.
- HEAD "The ", BODY "quic", "k br", "own ", "fox ", "jump", "s ov", "er t", "he l", "azy ", "dog.", then TAIL → cnt=11. Then:
  - STORE limm=15 → rf_dataw=0x54686520.
  - limm=14 → 0x71756963.
  - limm=5 → 0x646F672E.
  - limm=4 → 0.
- SHROT with a=0x80000001, b=1: SLL→0x00000002, SRL→0x40000000, SRA→0xC0000000, ROR→0xC0000000.
- 17 consecutive BODY after HEAD → cnt saturates at 16. limm=0 holds the 16th word. BODY after TAIL changes nothing.
- rfwb_op[0]=0 → rf_dataw holds. rst=0 mid-message → all state 0, and STORE limm=15 returns 0.
- macrc_op=1, mult_mac_result=0xDEADBEEF, any alu_op → rf_dataw=0xDEADBEEF. CMOV flag=1 → a; flag=0 → b.
